// File: rtl/sseg_number_writer_pkg.sv
// Shared types and constants for the seven-segment number writer:
// FSM state encoding, BCD digit width and a decimal power helper.
package sseg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CONV,
        WRITE,
        DONE
    } state_t;

    localparam int BCD_W = 4;

    function automatic int unsigned pow10(input int n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/sseg_number_writer_if.sv
// Request/response and digit-write bundle between a number source and the
// writer; the writer side (slave) drives the per-digit burst into sseg_array.
interface sseg_number_writer_if #(
    parameter int SSEG_BITS = 2,
    parameter int VAL_BITS  = 14
) ();
    import sseg_pkg::*;

    // start is a one-cycle request that is honoured only while busy is low;
    // value/blank_lz/dp_en/dp_sel need only be valid in that cycle. Each
    // accepted request yields one wr per digit, then a single done_tick.
    logic                 start;
    logic [VAL_BITS-1:0]  value;
    logic                 blank_lz;
    logic                 dp_en;
    logic [SSEG_BITS-1:0] dp_sel;
    logic                 wr;
    logic [SSEG_BITS-1:0] sel;
    logic [3:0]           val;
    logic                 en;
    logic                 sign;
    logic                 dp;
    logic                 busy;
    logic                 done_tick;
    logic                 ovf;
    state_t               state_dbg;

    modport master (
        output start, value, blank_lz, dp_en, dp_sel,
        input  wr, sel, val, en, sign, dp, busy, done_tick, ovf, state_dbg
    );

    modport slave (
        input  start, value, blank_lz, dp_en, dp_sel,
        output wr, sel, val, en, sign, dp, busy, done_tick, ovf, state_dbg
    );

endinterface

// File: rtl/sseg_number_writer_bin2bcd.sv
// Sequential double-dabble converter: one input bit per clock, MSB first.
// The first bit is shifted in on load, so done pulses VAL_BITS-1 steps later.
module bin2bcd_seq
    import sseg_pkg::*;
#(
    parameter int VAL_BITS = 14,
    parameter int SSEG_N   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [VAL_BITS-1:0]       bin,
    output logic [BCD_W*SSEG_N-1:0]   bcd,
    output logic                      done
);
    localparam int BCD_BITS = BCD_W * SSEG_N;
    localparam int CNT_W    = $clog2(VAL_BITS + 1);

    logic [VAL_BITS-1:0] sh;
    logic [CNT_W-1:0]    cnt;

    function automatic logic [BCD_BITS-1:0] dabble(input logic [BCD_BITS-1:0] b,
                                                   input logic in_bit);
        logic [BCD_BITS-1:0] adj;
        adj = b;
        for (int d = 0; d < SSEG_N; d++) begin
            if (adj[BCD_W*d +: BCD_W] >= 4'd5)
                adj[BCD_W*d +: BCD_W] = adj[BCD_W*d +: BCD_W] + 4'd3;
        end
        return {adj[BCD_BITS-2:0], in_bit};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            sh   <= '0;
            cnt  <= '0;
            bcd  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                // Shifting the MSB into an all-zero register needs no adjust.
                bcd  <= BCD_BITS'(bin[VAL_BITS-1]);
                sh   <= bin << 1;
                cnt  <= CNT_W'(VAL_BITS - 1);
                done <= (VAL_BITS == 1);
            end else if (cnt != '0) begin
                bcd  <= dabble(bcd, sh[VAL_BITS-1]);
                sh   <= sh << 1;
                cnt  <= cnt - 1'b1;
                done <= (cnt == CNT_W'(1));
            end
        end
    end

endmodule

// File: rtl/sseg_number_writer.sv
// Formats a signed value into a burst of per-digit writes for sseg_array:
// saturation, BCD conversion, leading-zero blanking, sign and decimal point.
module sseg_number_writer
    import sseg_pkg::*;
#(
    parameter int SSEG_BITS = 2,
    parameter int SSEG_N    = 4,
    parameter int VAL_BITS  = 14
) (
    input logic clk,
    input logic reset,
    sseg_number_writer_if.slave bus
);
    localparam int BCD_BITS = BCD_W * SSEG_N;
    localparam int unsigned POS_MAX = pow10(SSEG_N) - 1;
    localparam int unsigned NEG_MAX = pow10(SSEG_N - 1) - 1;
    localparam logic [SSEG_BITS-1:0] LAST = SSEG_BITS'(SSEG_N - 1);

    state_t               state, state_n;
    logic [SSEG_BITS-1:0] idx, idx_n;
    logic [VAL_BITS-1:0]  value_r, mag_abs, mag_sat;
    logic                 blank_r, dp_en_r, neg_r, sat;
    logic [SSEG_BITS-1:0] dp_sel_r;
    int unsigned          limit;
    logic                 core_load, core_done;
    logic [BCD_BITS-1:0]  bcd, bcd_hi;
    logic [BCD_W-1:0]     val_n;
    logic                 en_n, sign_n, dp_n, dp_here, dp_keep, in_write;

    assign bus.state_dbg = state;

    // The unsigned magnitude keeps the most negative input representable.
    always_comb begin
        mag_abs = value_r[VAL_BITS-1] ? (~value_r + 1'b1) : value_r;
        limit   = value_r[VAL_BITS-1] ? NEG_MAX : POS_MAX;
        sat     = 32'(mag_abs) > limit;
        mag_sat = sat ? VAL_BITS'(limit) : mag_abs;
    end

    bin2bcd_seq #(
        .VAL_BITS (VAL_BITS),
        .SSEG_N   (SSEG_N)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (core_load),
        .bin   (mag_sat),
        .bcd   (bcd),
        .done  (core_done)
    );

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        core_load = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_n = LOAD;
            LOAD:  begin
                state_n   = CONV;
                core_load = 1'b1;
            end
            CONV:  if (core_done) begin
                state_n = WRITE;
                idx_n   = '0;
            end
            WRITE: if (idx == LAST) state_n = DONE;
                   else idx_n = idx + 1'b1;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Digit formatting looks at the digit about to be written (idx_n) so the
    // write outputs can be registered.
    always_comb begin
        in_write = (state_n == WRITE);
        bcd_hi   = bcd >> (BCD_W * int'(idx_n));
        dp_here  = dp_en_r && (dp_sel_r == idx_n);
        dp_keep  = dp_en_r && (idx_n <= dp_sel_r);
        val_n    = bcd_hi[BCD_W-1:0];
        en_n     = 1'b1;
        sign_n   = 1'b0;
        dp_n     = dp_here;
        if (neg_r && idx_n == LAST) begin
            val_n  = '0;
            sign_n = 1'b1;
            dp_n   = 1'b0;
        end else if (blank_r && idx_n != '0 && bcd_hi == '0 && !dp_keep) begin
            val_n = '0;
            en_n  = 1'b0;
            dp_n  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            value_r       <= '0;
            blank_r       <= 1'b0;
            dp_en_r       <= 1'b0;
            dp_sel_r      <= '0;
            neg_r         <= 1'b0;
            bus.wr        <= 1'b0;
            bus.sel       <= '0;
            bus.val       <= '0;
            bus.en        <= 1'b0;
            bus.sign      <= 1'b0;
            bus.dp        <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done_tick <= 1'b0;
            bus.ovf       <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (state == IDLE && bus.start) begin
                value_r  <= bus.value;
                blank_r  <= bus.blank_lz;
                dp_en_r  <= bus.dp_en;
                dp_sel_r <= bus.dp_sel;
            end
            if (state == LOAD) begin
                neg_r   <= value_r[VAL_BITS-1];
                bus.ovf <= sat;
            end
            bus.wr        <= in_write;
            bus.sel       <= in_write ? idx_n : '0;
            bus.val       <= in_write ? val_n : '0;
            bus.en        <= in_write && en_n;
            bus.sign      <= in_write && sign_n;
            bus.dp        <= in_write && dp_n;
            bus.busy      <= (state_n != IDLE);
            bus.done_tick <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_sseg_number_writer.sv
// Bench for sseg_number_writer: decimal-arithmetic reference model feeding an
// expected-write queue, a per-cycle compare process and directed/random ops.
module tb_sseg_number_writer;
    import sseg_pkg::*;

    localparam int SSEG_BITS = 2;
    localparam int SSEG_N    = 4;
    localparam int VAL_BITS  = 14;
    localparam int W         = SSEG_BITS + 7;
    localparam int T_WR      = 2 + VAL_BITS;
    localparam int T_DONE    = 2 + VAL_BITS + SSEG_N;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sseg_number_writer_if #(.SSEG_BITS(SSEG_BITS), .VAL_BITS(VAL_BITS)) bus ();

    sseg_number_writer #(
        .SSEG_BITS (SSEG_BITS),
        .SSEG_N    (SSEG_N),
        .VAL_BITS  (VAL_BITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs[SSEG_N];
    int   n_wr = 0;
    int   n_done = 0;
    int   model_j = 0;
    logic model_active = 1'b0;
    logic ovf_exp = 1'b0;
    logic ovf_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rec(input int s, input int v, input int e,
                                         input int sg, input int d);
        return W'((s << 7) | (v << 3) | (e << 2) | (sg << 1) | d);
    endfunction

    // Reference: decimal digits by division, blanking by "remaining value is zero".
    task automatic model_push(input int v, input int bl, input int de, input int ds);
        int neg, mag, lim, upper, dig, p;
        neg = (v < 0) ? 1 : 0;
        mag = neg ? -v : v;
        lim = neg ? (10 ** (SSEG_N - 1)) - 1 : (10 ** SSEG_N) - 1;
        ovf_pend = (mag > lim);
        if (mag > lim) mag = lim;
        p = 1;
        for (int i = 0; i < SSEG_N; i++) begin
            upper = mag / p;
            dig   = upper % 10;
            if (neg != 0 && i == SSEG_N - 1)
                exp_q.push_back(rec(i, 0, 1, 1, 0));
            else if (bl != 0 && i > 0 && upper == 0 && !(de != 0 && i <= ds))
                exp_q.push_back(rec(i, 0, 0, 0, 0));
            else
                exp_q.push_back(rec(i, dig, 1, 0, (de != 0 && ds == i) ? 1 : 0));
            p = p * 10;
        end
    endtask

    // Compare process: every cycle, against the model's cycle position.
    initial begin
        logic [W-1:0] act;
        logic [2:0]   exp_ctl;
        @(posedge clk);
        forever begin
            @(negedge clk);
            act = {bus.sel, bus.val, bus.en, bus.sign, bus.dp};
            if (model_active) begin
                model_j++;
                if (model_j == 2) ovf_exp = ovf_pend;
                exp_ctl = {model_j <= T_DONE, model_j >= T_WR && model_j < T_DONE,
                           model_j == T_DONE};
            end else begin
                exp_ctl = 3'b000;
            end
            check("busy_wr_done", {29'd0, bus.busy, bus.wr, bus.done_tick}, {29'd0, exp_ctl});
            check("ovf", {31'd0, bus.ovf}, {31'd0, ovf_exp});
            if (bus.wr) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL write_extra: got %0h expected no write at %0t", act, $time);
                end else begin
                    check("write", {23'd0, act}, {23'd0, exp_q.pop_front()});
                end
                if (n_wr < SSEG_N) obs[n_wr] = act;
                n_wr++;
            end else begin
                check("idle_outs", {23'd0, act}, 32'd0);
            end
            if (bus.done_tick) n_done++;
            if (model_active && model_j > T_DONE) model_active = 1'b0;
        end
    end

    // poke_at: cycle in which a second start is pulsed; rst_at: cycle in which reset is held.
    task automatic run_op(input int v, input int bl, input int de, input int ds,
                          input int poke_at, input int rst_at);
        int exp_wr, exp_dn;
        @(negedge clk);
        bus.value    = VAL_BITS'(v);
        bus.blank_lz = bl[0];
        bus.dp_en    = de[0];
        bus.dp_sel   = SSEG_BITS'(ds);
        bus.start    = 1'b1;
        model_push(v, bl, de, ds);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        model_j      = 0;
        model_active = 1'b1;
        n_wr         = 0;
        n_done       = 0;
        bus.value    = VAL_BITS'($urandom);
        bus.blank_lz = 1'($urandom_range(0, 1));
        bus.dp_en    = 1'($urandom_range(0, 1));
        bus.dp_sel   = SSEG_BITS'($urandom_range(0, 3));
        for (int c = 0; c < 40 && model_active; c++) begin
            @(posedge clk);
            #2;
            bus.start = (poke_at != 0 && model_j == poke_at - 1);
            if (rst_at != 0 && model_j == rst_at - 1) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset        = 1'b0;
                model_active = 1'b0;
                exp_q.delete();
                ovf_exp      = 1'b0;
                ovf_pend     = 1'b0;
            end
        end
        bus.start = 1'b0;
        if (model_active) begin
            total++;
            bad++;
            $display("FAIL op_timeout: got no completion expected done_tick by cycle %0d", T_DONE);
            model_active = 1'b0;
        end
        exp_wr = (rst_at != 0) ? rst_at - T_WR + 1 : SSEG_N;
        exp_dn = (rst_at != 0) ? 0 : 1;
        check("write_count", n_wr, exp_wr);
        check("done_count", n_done, exp_dn);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_obs(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] d);
        check({name, "_d0"}, {23'd0, obs[0]}, {23'd0, a});
        check({name, "_d1"}, {23'd0, obs[1]}, {23'd0, b});
        check({name, "_d2"}, {23'd0, obs[2]}, {23'd0, c});
        check({name, "_d3"}, {23'd0, obs[3]}, {23'd0, d});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v, bl, de, ds;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.value    = '0;
        bus.blank_lz = 1'b0;
        bus.dp_en    = 1'b0;
        bus.dp_sel   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_state", {bus.wr, bus.sel, bus.val, bus.en, bus.sign, bus.dp,
                              bus.busy, bus.done_tick, bus.ovf}, 32'd0);

        run_op(1234, 1, 0, 0, 0, 0);
        check_obs("p1234", rec(0, 4, 1, 0, 0), rec(1, 3, 1, 0, 0), rec(2, 2, 1, 0, 0), rec(3, 1, 1, 0, 0));
        check("ovf_1234", bus.ovf, 0);

        run_op(-42, 1, 0, 0, 0, 0);
        check_obs("n42", rec(0, 2, 1, 0, 0), rec(1, 4, 1, 0, 0), rec(2, 0, 0, 0, 0), rec(3, 0, 1, 1, 0));

        run_op(5, 1, 1, 2, 0, 0);
        check_obs("p5dp2", rec(0, 5, 1, 0, 0), rec(1, 0, 1, 0, 0), rec(2, 0, 1, 0, 1), rec(3, 0, 0, 0, 0));

        // Largest positive 14-bit input stays below the four-digit limit.
        run_op(8191, 0, 0, 0, 0, 0);
        check_obs("p8191", rec(0, 1, 1, 0, 0), rec(1, 9, 1, 0, 0), rec(2, 1, 1, 0, 0), rec(3, 8, 1, 0, 0));
        check("ovf_8191", bus.ovf, 0);

        run_op(-8192, 1, 0, 0, 0, 0);
        check_obs("n8192", rec(0, 9, 1, 0, 0), rec(1, 9, 1, 0, 0), rec(2, 9, 1, 0, 0), rec(3, 0, 1, 1, 0));
        check("ovf_n8192", bus.ovf, 1);

        run_op(-999, 1, 0, 0, 0, 0);
        check("ovf_n999", bus.ovf, 0);
        run_op(-1000, 1, 0, 0, 0, 0);
        check("ovf_n1000", bus.ovf, 1);

        run_op(0, 1, 0, 0, 0, 0);
        check_obs("zero", rec(0, 0, 1, 0, 0), rec(1, 0, 0, 0, 0), rec(2, 0, 0, 0, 0), rec(3, 0, 0, 0, 0));

        run_op(-5000, 0, 0, 0, 8, 0);
        check("ovf_poke", bus.ovf, 1);
        run_op(7, 1, 0, 0, 0, 0);
        check("ovf_cleared", bus.ovf, 0);

        run_op(-1234, 1, 0, 0, 0, T_WR + 1);
        check("after_reset", {bus.busy, bus.wr, bus.done_tick, bus.ovf}, 32'd0);
        run_op(4321, 1, 1, 0, 0, 0);
        check_obs("p4321", rec(0, 1, 1, 0, 1), rec(1, 2, 1, 0, 0), rec(2, 3, 1, 0, 0), rec(3, 4, 1, 0, 0));

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1)
                v = int'($urandom_range(0, 16383)) - 8192;
            else
                v = ($urandom_range(0, 1) == 1) ? -int'($urandom_range(0, 200))
                                                : int'($urandom_range(0, 200));
            bl = int'($urandom_range(0, 1));
            de = int'($urandom_range(0, 1));
            ds = int'($urandom_range(0, 3));
            run_op(v, bl, de, ds, 0, 0);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
